// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master valid/ready memory port arbiter with stall watchdog
// Optional build macro ARB_ROUND_ROBIN_EN selects alternating fairness instead of fixed M0 priority.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_m0_addr,
  input  logic [31:0]           i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  input  logic                  i_m0_wr_valid,
  input  logic                  i_m1_wr_valid,
  output logic                  o_m0_wr_ready,
  output logic                  o_m1_wr_ready,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_m0_rd_valid,
  output logic                  o_m1_rd_valid,
  input  logic                  i_m0_rd_ready,
  input  logic                  i_m1_rd_ready,
  output logic [31:0]           o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic [1:0]            o_grant,
  output logic                  o_timeout
);

  // State codes are one-hot so the grant output is the state register itself.
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_GRANT0 = 2'b01;
  localparam logic [1:0] S_GRANT1 = 2'b10;

  localparam logic [7:0] MAX_CNT  = 8'(MAX_WAIT);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic req0, req1;
  logic g0, g1;
  logic handshake;

  assign req0 = i_m0_wr_valid | i_m0_rd_ready;
  assign req1 = i_m1_wr_valid | i_m1_rd_ready;
  assign g0   = (state_q == S_GRANT0);
  assign g1   = (state_q == S_GRANT1);

  always_comb begin
    o_addr     = '0;
    o_data     = '0;
    o_wr_valid = 1'b0;
    o_rd_ready = 1'b0;
    if (g0) begin
      o_addr     = i_m0_addr;
      o_data     = i_m0_data;
      o_wr_valid = i_m0_wr_valid;
      o_rd_ready = i_m0_rd_ready;
    end else if (g1) begin
      o_addr     = i_m1_addr;
      o_data     = i_m1_data;
      o_wr_valid = i_m1_wr_valid;
      o_rd_ready = i_m1_rd_ready;
    end
  end

  // Slave-side outputs are already zero in IDLE, so this never fires there.
  assign handshake = (o_wr_valid & i_wr_ready) | (i_rd_valid & o_rd_ready);

  assign o_m0_wr_ready = g0 & i_wr_ready;
  assign o_m0_rd_valid = g0 & i_rd_valid;
  assign o_m0_data     = g0 ? i_data : '0;
  assign o_m1_wr_ready = g1 & i_wr_ready;
  assign o_m1_rd_valid = g1 & i_rd_valid;
  assign o_m1_data     = g1 ? i_data : '0;

  assign o_grant   = state_q;
  assign o_timeout = timeout_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_q ? S_GRANT0 : S_GRANT1;
`else
          state_d = S_GRANT0;
`endif
        end else if (req0) begin
          state_d = S_GRANT0;
        end else if (req1) begin
          state_d = S_GRANT1;
        end
      end
      S_GRANT0: begin
        if (handshake) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end else if (!req0) begin
          state_d = S_IDLE;
        end
      end
      S_GRANT1: begin
        if (handshake) begin
          state_d = S_IDLE;
          last_d  = 1'b1;
        end else if (!req1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every grant is entered from IDLE, so holding the counter at zero there clears it on entry.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (state_q == S_IDLE) begin
      wait_cnt_d = 8'd0;
    end else if (!handshake && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if ((state_q != S_IDLE) && (wait_cnt_d == MAX_CNT)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (reads, writes, fairness, abort, watchdog, reset)
module tb_mem_arbiter;

  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_wr_valid, m1_wr_valid, m0_rd_ready, m1_rd_ready;
  logic        s_wr_ready, s_rd_valid;
  logic [31:0] s_rdata;

  logic        o_m0_wr_ready, o_m1_wr_ready, o_m0_rd_valid, o_m1_rd_valid;
  logic [31:0] o_m0_data, o_m1_data, o_addr, o_data;
  logic        o_wr_valid, o_rd_ready, o_timeout;
  logic [1:0]  o_grant;

  int    n_checks = 0;
  int    n_errors = 0;
  xfer_t sb_q[$];
  int    exp_last;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
    .i_m0_data(m0_wdata), .i_m1_data(m1_wdata),
    .i_m0_wr_valid(m0_wr_valid), .i_m1_wr_valid(m1_wr_valid),
    .o_m0_wr_ready(o_m0_wr_ready), .o_m1_wr_ready(o_m1_wr_ready),
    .o_m0_data(o_m0_data), .o_m1_data(o_m1_data),
    .o_m0_rd_valid(o_m0_rd_valid), .o_m1_rd_valid(o_m1_rd_valid),
    .i_m0_rd_ready(m0_rd_ready), .i_m1_rd_ready(m1_rd_ready),
    .o_addr(o_addr), .o_data(o_data), .o_wr_valid(o_wr_valid),
    .i_wr_ready(s_wr_ready), .i_data(s_rdata), .i_rd_valid(s_rd_valid),
    .o_rd_ready(o_rd_ready), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_wr_valid = wr; m0_rd_ready = rd; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_wr_valid = wr; m1_rd_ready = rd; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  task automatic expect_xfer(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    xfer_t e;
    e.m = m; e.wr = wr; e.addr = addr; e.data = data;
    sb_q.push_back(e);
    exp_last = m;
  endtask

  function automatic logic [1:0] grant_of(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  // Winner of a simultaneous request in IDLE according to the reference arbitration policy.
  function automatic int pick_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (exp_last == 1) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic do_read(input int m, input logic [31:0] addr, input logic [31:0] data);
    set_m(m, 1'b0, 1'b1, addr, 32'h0);
    check_eq("rd_req_grant_wait", {30'b0, o_grant}, 32'h0);
    tick();
    check_eq("rd_grant", {30'b0, o_grant}, {30'b0, grant_of(m)});
    check_eq("rd_addr", o_addr, addr);
    check_eq("rd_ready_out", {31'b0, o_rd_ready}, 32'd1);
    expect_xfer(m, 1'b0, addr, data);
    s_rdata = data;
    s_rd_valid = 1'b1;
    #1;
    check_eq("rd_valid_routed", {31'b0, (m == 0) ? o_m0_rd_valid : o_m1_rd_valid}, 32'd1);
    check_eq("rd_other_valid", {31'b0, (m == 0) ? o_m1_rd_valid : o_m0_rd_valid}, 32'd0);
    check_eq("rd_other_data", (m == 0) ? o_m1_data : o_m0_data, 32'h0);
    tick();
    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;
    check_eq("rd_idle_after", {30'b0, o_grant}, 32'h0);
  endtask

  // Scoreboard: every master-side handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    logic        hw, hr;
    logic [31:0] rdat;
    xfer_t       e;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        hw   = (m == 0) ? (m0_wr_valid & o_m0_wr_ready) : (m1_wr_valid & o_m1_wr_ready);
        hr   = (m == 0) ? (m0_rd_ready & o_m0_rd_valid) : (m1_rd_ready & o_m1_rd_valid);
        rdat = (m == 0) ? o_m0_data : o_m1_data;
        if (hw || hr) begin
          check_eq("sb_pending", {31'b0, sb_q.size() > 0}, 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_master", m, e.m);
            check_eq("sb_kind", {31'b0, hw}, {31'b0, e.wr});
            check_eq("sb_addr", o_addr, e.addr);
            check_eq("sb_data", hw ? o_data : rdat, e.data);
          end
        end
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    exp_last = 1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_wr_ready = 1'b0; s_rd_valid = 1'b0; s_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", {30'b0, o_grant}, 32'h0);
    check_eq("rst_timeout", {31'b0, o_timeout}, 32'd0);
    check_eq("rst_slave_out", {o_addr[29:0], o_wr_valid, o_rd_ready}, 32'h0);
    check_eq("rst_master_out", {28'b0, o_m0_wr_ready, o_m1_wr_ready, o_m0_rd_valid, o_m1_rd_valid}, 32'h0);
    rst = 1'b0;

    // M0 read
    do_read(0, 32'h10, 32'hDEADBEEF);

    // M1 write with memory holding wr_ready low for three cycles
    set_m(1, 1'b1, 1'b0, 32'h7BC, 32'hC000C000);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("wr_hold_grant", {30'b0, o_grant}, 32'h2);
      check_eq("wr_hold_valid", {31'b0, o_wr_valid}, 32'd1);
      check_eq("wr_hold_ready", {31'b0, o_m1_wr_ready}, 32'd0);
      check_eq("wr_hold_addr", o_addr, 32'h7BC);
      tick();
    end
    expect_xfer(1, 1'b1, 32'h7BC, 32'hC000C000);
    s_wr_ready = 1'b1;
    #1;
    check_eq("wr_accept", {31'b0, o_m1_wr_ready}, 32'd1);
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_wr_ready = 1'b0;
    check_eq("wr_idle_after", {30'b0, o_grant}, 32'h0);

    // Both masters requesting persistently against an always-ready memory
    set_m(0, 1'b0, 1'b1, 32'h100, 32'h0);
    set_m(1, 1'b0, 1'b1, 32'h200, 32'h0);
    s_rd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      w = pick_winner();
      s_rdata = 32'h5A5A0000 + k;
      check_eq("fair_grant", {30'b0, o_grant}, {30'b0, grant_of(w)});
      check_eq("fair_addr", o_addr, (w == 0) ? 32'h100 : 32'h200);
      expect_xfer(w, 1'b0, (w == 0) ? 32'h100 : 32'h200, 32'h5A5A0000 + k);
      tick();
      check_eq("fair_bubble", {30'b0, o_grant}, 32'h0);
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;

    // Abort: M1 drops its read before memory answers
    do_read(0, 32'h20, 32'h00C0FFEE);
    set_m(1, 1'b0, 1'b1, 32'h300, 32'h0);
    tick();
    check_eq("abort_grant", {30'b0, o_grant}, 32'h2);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("abort_rd_ready_drop", {31'b0, o_rd_ready}, 32'd0);
    tick();
    check_eq("abort_idle", {30'b0, o_grant}, 32'h0);
    set_m(0, 1'b0, 1'b1, 32'h400, 32'h0);
    set_m(1, 1'b0, 1'b1, 32'h480, 32'h0);
    tick();
    w = pick_winner();
    check_eq("abort_next_grant", {30'b0, o_grant}, {30'b0, grant_of(w)});
    expect_xfer(w, 1'b0, (w == 0) ? 32'h400 : 32'h480, 32'h11112222);
    s_rdata = 32'h11112222;
    s_rd_valid = 1'b1;
    tick();
    set_m(w, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;
    check_eq("abort_bubble", {30'b0, o_grant}, 32'h0);
    tick();
    check_eq("abort_loser_grant", {30'b0, o_grant}, {30'b0, grant_of(1 - w)});
    expect_xfer(1 - w, 1'b0, (w == 0) ? 32'h480 : 32'h400, 32'h33334444);
    s_rdata = 32'h33334444;
    s_rd_valid = 1'b1;
    tick();
    set_m(1 - w, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;
    check_eq("abort_done_idle", {30'b0, o_grant}, 32'h0);

    // Watchdog with MAX_WAIT = 4
    set_m(0, 1'b1, 1'b0, 32'h40, 32'h0BADF00D);
    tick();
    check_eq("wd_grant", {30'b0, o_grant}, 32'h1);
    check_eq("wd_stall1", {31'b0, o_timeout}, 32'd0);
    tick();
    check_eq("wd_stall2", {31'b0, o_timeout}, 32'd0);
    tick();
    check_eq("wd_stall3", {31'b0, o_timeout}, 32'd0);
    tick();
    tick();
    check_eq("wd_flagged", {31'b0, o_timeout}, 32'd1);
    check_eq("wd_grant_kept", {30'b0, o_grant}, 32'h1);
    expect_xfer(0, 1'b1, 32'h40, 32'h0BADF00D);
    s_wr_ready = 1'b1;
    #1;
    check_eq("wd_accept", {31'b0, o_m0_wr_ready}, 32'd1);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_wr_ready = 1'b0;
    check_eq("wd_idle", {30'b0, o_grant}, 32'h0);
    check_eq("wd_sticky", {31'b0, o_timeout}, 32'd1);

    // Asynchronous reset in the middle of an M1 read
    set_m(1, 1'b0, 1'b1, 32'h300, 32'h0);
    tick();
    check_eq("rstmid_grant", {30'b0, o_grant}, 32'h2);
    s_rdata = 32'hFFFF0000;
    s_rd_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check_eq("rstmid_grant_drop", {30'b0, o_grant}, 32'h0);
    check_eq("rstmid_rd_ready", {31'b0, o_rd_ready}, 32'd0);
    check_eq("rstmid_rd_valid", {31'b0, o_m1_rd_valid}, 32'd0);
    check_eq("rstmid_addr", o_addr, 32'h0);
    check_eq("rstmid_timeout", {31'b0, o_timeout}, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;
    exp_last = 1;
    tick();
    rst = 1'b0;

    // After reset both policies give M0 the first simultaneous grant
    set_m(0, 1'b0, 1'b1, 32'h500, 32'h0);
    set_m(1, 1'b0, 1'b1, 32'h600, 32'h0);
    tick();
    check_eq("post_rst_grant0", {30'b0, o_grant}, 32'h1);
    expect_xfer(0, 1'b0, 32'h500, 32'hAAAA0001);
    s_rdata = 32'hAAAA0001;
    s_rd_valid = 1'b1;
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;
    check_eq("post_rst_bubble", {30'b0, o_grant}, 32'h0);
    tick();
    check_eq("post_rst_grant1", {30'b0, o_grant}, 32'h2);
    expect_xfer(1, 1'b0, 32'h600, 32'hAAAA0002);
    s_rdata = 32'hAAAA0002;
    s_rd_valid = 1'b1;
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rd_valid = 1'b0;
    check_eq("post_rst_idle", {30'b0, o_grant}, 32'h0);

    tick();
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
